dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Single-port data-memory arbiter for the pipelined core. It shares the one data `MemoryModule` (128 words, word-addressed, combinational read, write on clock edge) between the Mem_1 pipeline stage and a host/debug requester. The pipeline has fixed priority and is never delayed, except that an optional starvation guard can force one stall cycle so a host request is served. The block sits between Mem_1's stage registers and the data memory instance.

## Interface
Parameters:
- `STARVE_LIMIT`, 8: consecutive blocked host cycles before a forced grant (≥2).
- `AW`, 7: memory word-address width.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `pipe_oper`  in  1  valid instruction in Mem_1.
- `pipe_readmem`  in  1  load.
- `pipe_writemem`  in  1  store.
- `pipe_addr`  in  32  byte address; bits [8:2] used.
- `pipe_wdata`  in  32  store data.
- `pipe_rdata`  out  32  load data, combinational from `mem_rdata`.
- `pipe_stall`  out  1  registered; upstream holds Mem_1 inputs this cycle.
- `host_req`  in  1  host request; held until granted.
- `host_we`  in  1  1 = write, 0 = read.
- `host_addr`  in  AW  word address.
- `host_wdata`  in  32  write data.
- `host_gnt`  out  1  combinational; access performed at this clock edge.
- `host_rvalid`  out  1  registered; one-cycle pulse with read data.
- `host_rdata`  out  32  registered read data.
- `mem_addr`  out  AW  to memory.
- `mem_wdata`  out  32  to memory.
- `mem_we`  out  1  to memory.
- `mem_rdata`  in  32  from memory.

## Operation
- `pipe_access` = `pipe_oper & (pipe_readmem | pipe_writemem)`. Pipeline write = `pipe_oper & ~pipe_readmem & pipe_writemem`; read wins if both flags are set.
- `host_gnt` = `host_req & (~pipe_access | state==STALL)`.
- Memory mux: when `host_gnt` is high, drive host addr/wdata/we. Otherwise drive the pipeline addr/wdata and pipeline write. In STALL the pipeline write is suppressed.
- FSM states:
  - IDLE: if `host_req & pipe_access`, go to WAIT with cnt=1. Otherwise stay.
  - WAIT: if `host_gnt`, go to IDLE with cnt=0. If `host_req` drops, go to IDLE with cnt=0. Otherwise cnt++. When the incremented cnt equals `STARVE_LIMIT`, go to STALL.
  - STALL: lasts exactly one cycle, then IDLE with cnt=0. `pipe_stall`=1 only in STALL.
- Host read: on a granted edge with `host_we`=0, capture `mem_rdata` into `host_rdata` and set `host_rvalid`=1 for the next cycle. Otherwise `host_rvalid`=0 and `host_rdata` holds its value.
- Protocol violation: if `host_req` is low in STALL, no host access occurs. The stall still happens.

## Timing
- Reset values: state IDLE, cnt 0, `pipe_stall` 0, `host_rvalid` 0, `host_rdata` 0. Combinational outputs follow their inputs during reset.
- Pipeline: zero added latency. `pipe_rdata` is valid in the same cycle, as before.
- Host: grant occurs in the first cycle with no pipeline access. Read data arrives 1 cycle after the grant edge.
- Worst-case host wait with the guard: `STARVE_LIMIT` blocked cycles, with the grant in cycle `STARVE_LIMIT`+1.
- Simultaneous pipeline and host access: the pipeline wins, except in STALL.
- Reset asserted mid-transaction: the pending request is dropped and any in-flight `host_rvalid` is cleared. The host must re-request.

## Configuration
- `DMEM_ARB_STARVE_EN` defined: starvation counter and STALL state are present, as described above.
- Not defined: no counter and no STALL state. `pipe_stall` is tied to 0, and the host is served only in pipeline-idle cycles, so unbounded waiting is allowed.

## Structure
- The shared package holds:
  - FSM state encoding (IDLE/WAIT/STALL, 2 bits).
  - `DMEM_AW`=7.
  - Address slice constants [8:2].
- Sub-module `dmem_starve_cnt`: saturating wait counter with limit-reached output. It is instantiated only under the macro.

## Test plan
- Host read of addr 5 (holding 0xDEADBEEF) while `pipe_oper`=0 → `host_gnt` in the same cycle; `host_rvalid`=1 with `host_rdata`=0xDEADBEEF one cycle later.
- Pipeline store to byte addr 0x10 with 0x1234 while a host write to word 4 is pending → pipeline write goes first. The host write lands on the next idle cycle, and word 4 reads 0x1234 afterwards only if the host did not overwrite it.
- Macro on, `STARVE_LIMIT`=8, pipeline load every cycle, host request held → 8 blocked cycles; 9th cycle has `pipe_stall`=1 and `host_gnt`=1; `mem_we` from the pipeline is suppressed.
- Macro off, same stimulus for 50 cycles → `host_gnt` never asserts and `pipe_stall` stays 0.
- Reset pulsed low in WAIT with cnt=5 → all registered outputs 0 and state IDLE; a fresh count starts at 1.
- `pipe_readmem`=`pipe_writemem`=1 → treated as a read, `mem_we`=0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

    // Arbiter FSM encoding; WAIT and STALL are only reachable with DMEM_ARB_STARVE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2
    } arb_state_e;

    localparam int DMEM_AW = 7;

    // Word-address slice of the pipeline byte address
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 2;

    function automatic logic [DMEM_AW-1:0] word_addr(input logic [31:0] byte_addr);
        return byte_addr[ADDR_HI:ADDR_LO];
    endfunction

endpackage

// File: rtl/dmem_starve_cnt.sv
// rtl/dmem_starve_cnt.sv - saturating host wait counter with limit-reached flag
module dmem_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic load_one_i,
    input  logic inc_i,
    output logic limit_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, then load-one, then saturating increment
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_one_i) begin
            cnt_d = CW'(1);
        end else if (inc_i && (32'(cnt_q) < 32'(LIMIT))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High when the coming increment reaches the limit
    assign limit_o = ((32'(cnt_q) + 32'd1) == 32'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data memory arbiter (pipeline vs host), starvation guard under DMEM_ARB_STARVE_EN
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int AW           = DMEM_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pipe_oper,
    input  logic          pipe_readmem,
    input  logic          pipe_writemem,
    input  logic [31:0]   pipe_addr,
    input  logic [31:0]   pipe_wdata,
    output logic [31:0]   pipe_rdata,
    output logic          pipe_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [31:0]   host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);

    logic        pipe_access;
    logic        pipe_we;
    logic        in_stall;
    logic        host_rd_fire;
    logic        host_rvalid_q;
    logic [31:0] host_rdata_q;

    // Only the word-address bits of the pipeline address reach the memory
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pipe_addr[31:ADDR_HI+1], pipe_addr[ADDR_LO-1:0]};

    assign pipe_access = pipe_oper & (pipe_readmem | pipe_writemem);
    // A load wins when both flags are set
    assign pipe_we     = pipe_oper & ~pipe_readmem & pipe_writemem;

`ifdef DMEM_ARB_STARVE_EN
    arb_state_e state_q;
    arb_state_e state_d;
    logic       cnt_clear;
    logic       cnt_load;
    logic       cnt_inc;
    logic       cnt_limit;

    dmem_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clock      (clock),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .load_one_i (cnt_load),
        .inc_i      (cnt_inc),
        .limit_o    (cnt_limit)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter control; a blocked host escalates to a one-cycle pipeline stall
    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_req && pipe_access) begin
                    state_d  = ST_WAIT;
                    cnt_load = 1'b1;
                end
            end
            ST_WAIT: begin
                if (host_gnt || !host_req) begin
                    state_d   = ST_IDLE;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                    if (cnt_limit) begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    assign in_stall   = (state_q == ST_STALL);
    assign pipe_stall = in_stall;
`else
    // Without the guard the host simply waits for a pipeline-idle cycle
    logic unused_cfg;
    assign unused_cfg = (STARVE_LIMIT < 2);
    assign in_stall   = 1'b0;
    assign pipe_stall = 1'b0;
`endif

    assign host_gnt = host_req & (~pipe_access | in_stall);

    // Memory port mux; a stalled pipeline store must not reach the memory
    always_comb begin
        mem_addr  = AW'(word_addr(pipe_addr));
        mem_wdata = pipe_wdata;
        mem_we    = pipe_we & ~in_stall;
        if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
            mem_we    = host_we;
        end
    end

    assign pipe_rdata   = mem_rdata;
    assign host_rd_fire = host_gnt & ~host_we;

    // Host read return: one-cycle valid pulse, data held between reads
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_rvalid_q <= host_rd_fire;
            if (host_rd_fire) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        pipe_oper;
    logic        pipe_readmem;
    logic        pipe_writemem;
    logic [31:0] pipe_addr;
    logic [31:0] pipe_wdata;
    logic [31:0] pipe_rdata;
    logic        pipe_stall;
    logic        host_req;
    logic        host_we;
    logic [6:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [31:0] host_rdata;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [128];

    dmem_arbiter #(
        .STARVE_LIMIT (8),
        .AW           (7)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pipe_oper     (pipe_oper),
        .pipe_readmem  (pipe_readmem),
        .pipe_writemem (pipe_writemem),
        .pipe_addr     (pipe_addr),
        .pipe_wdata    (pipe_wdata),
        .pipe_rdata    (pipe_rdata),
        .pipe_stall    (pipe_stall),
        .host_req      (host_req),
        .host_we       (host_we),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_gnt      (host_gnt),
        .host_rvalid   (host_rvalid),
        .host_rdata    (host_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: combinational read, write on the clock edge
    assign mem_rdata = mem[mem_addr];
    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_oper     = 1'b0;
        pipe_readmem  = 1'b0;
        pipe_writemem = 1'b0;
        pipe_addr     = 32'h0;
        pipe_wdata    = 32'h0;
        host_req      = 1'b0;
        host_we       = 1'b0;
        host_addr     = 7'd0;
        host_wdata    = 32'h0;
    endtask

    // Pipeline store to word 16 every cycle while the host holds a read of word 5
    task automatic block_host();
        pipe_oper     = 1'b1;
        pipe_readmem  = 1'b0;
        pipe_writemem = 1'b1;
        pipe_addr     = 32'h40;
        pipe_wdata    = 32'h55;
        host_req      = 1'b1;
        host_we       = 1'b0;
        host_addr     = 7'd5;
    endtask

`ifdef DMEM_ARB_STARVE_EN
    // Eight blocked cycles, then a stall cycle that serves the host
    task automatic run_starve();
        for (int i = 0; i < 8; i++) begin
            chk("blocked_gnt", {31'd0, host_gnt}, 32'd0);
            chk("blocked_stall", {31'd0, pipe_stall}, 32'd0);
            cyc();
        end
        chk("stall_cycle", {31'd0, pipe_stall}, 32'd1);
        chk("stall_gnt", {31'd0, host_gnt}, 32'd1);
        chk("stall_we", {31'd0, mem_we}, 32'd0);
        chk("stall_addr", {25'd0, mem_addr}, 32'd5);
        cyc();
        host_req = 1'b0;
        #1;
        chk("stall_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk("stall_rdata", host_rdata, 32'hDEADBEEF);
        chk("stall_over", {31'd0, pipe_stall}, 32'd0);
    endtask
`endif

    initial begin
        int gnt_seen;
        int stall_seen;
        idle_inputs();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("rst_rdata", host_rdata, 32'h0);
        chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
        reset = 1'b1;
        cyc();

        // Host write 0xDEADBEEF to word 5 with the pipeline idle
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'd5; host_wdata = 32'hDEADBEEF;
        #1;
        chk("hw_gnt", {31'd0, host_gnt}, 32'd1);
        chk("hw_we", {31'd0, mem_we}, 32'd1);
        chk("hw_addr", {25'd0, mem_addr}, 32'd5);
        cyc();
        chk("hw_no_rvalid", {31'd0, host_rvalid}, 32'd0);

        // Host read of word 5
        host_we = 1'b0;
        #1;
        chk("hr_gnt", {31'd0, host_gnt}, 32'd1);
        chk("hr_memdata", mem_rdata, 32'hDEADBEEF);
        cyc();
        host_req = 1'b0;
        #1;
        chk("hr_rvalid", {31'd0, host_rvalid}, 32'd1);
        chk("hr_rdata", host_rdata, 32'hDEADBEEF);
        cyc();
        chk("hr_rvalid_pulse", {31'd0, host_rvalid}, 32'd0);
        chk("hr_rdata_hold", host_rdata, 32'hDEADBEEF);

        // Pipeline store to 0x10 beats a pending host write to word 4
        pipe_oper = 1'b1; pipe_readmem = 1'b0; pipe_writemem = 1'b1;
        pipe_addr = 32'h10; pipe_wdata = 32'h1234;
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'd4; host_wdata = 32'hCAFE0000;
        #1;
        chk("ps_gnt", {31'd0, host_gnt}, 32'd0);
        chk("ps_we", {31'd0, mem_we}, 32'd1);
        chk("ps_addr", {25'd0, mem_addr}, 32'd4);
        chk("ps_wdata", mem_wdata, 32'h1234);
        cyc();
        pipe_oper = 1'b0;
        #1;
        chk("ps_host_gnt", {31'd0, host_gnt}, 32'd1);
        chk("ps_host_wdata", mem_wdata, 32'hCAFE0000);
        cyc();
        host_req = 1'b0;
        pipe_oper = 1'b1; pipe_readmem = 1'b1; pipe_writemem = 1'b0;
        #1;
        chk("ps_readback", pipe_rdata, 32'hCAFE0000);
        chk("ps_load_we", {31'd0, mem_we}, 32'd0);
        cyc();

        // Both flags set: treated as a load
        pipe_readmem = 1'b1; pipe_writemem = 1'b1; pipe_wdata = 32'hFFFF;
        host_req = 1'b1; host_we = 1'b1; host_addr = 7'd9;
        #1;
        chk("both_we", {31'd0, mem_we}, 32'd0);
        chk("both_gnt", {31'd0, host_gnt}, 32'd0);
        chk("both_rdata", pipe_rdata, 32'hCAFE0000);
        host_req = 1'b0;
        cyc();
        idle_inputs();
        cyc();
        cyc();

`ifdef DMEM_ARB_STARVE_EN
        block_host();
        run_starve();
        idle_inputs();
        cyc();

        // Reset in WAIT with cnt=5, then a fresh count
        block_host();
        repeat (5) cyc();
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", {31'd0, pipe_stall}, 32'd0);
        chk("mid_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("mid_rst_rdata", host_rdata, 32'h0);
        reset = 1'b1;
        #1;
        run_starve();
        idle_inputs();
        cyc();
`else
        // Host starved forever while the pipeline is busy
        block_host();
        gnt_seen = 0;
        stall_seen = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (host_gnt) gnt_seen++;
            if (pipe_stall) stall_seen++;
            cyc();
        end
        chk("nostarve_gnt_cnt", 32'(gnt_seen), 32'd0);
        chk("nostarve_stall_cnt", 32'(stall_seen), 32'd0);
        idle_inputs();
        cyc();

        // Reset clears a read return in flight
        host_req = 1'b1; host_we = 1'b0; host_addr = 7'd5;
        #1;
        chk("rr_gnt", {31'd0, host_gnt}, 32'd1);
        cyc();
        host_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_rvalid", {31'd0, host_rvalid}, 32'd0);
        chk("mid_rst_rdata", host_rdata, 32'h0);
        chk("mid_rst_stall", {31'd0, pipe_stall}, 32'd0);
        reset = 1'b1;
        cyc();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Overall time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
